// File: rtl/posit_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : posit_sched_pkg                                             |
// | Purpose  : Shared types and the round-robin helper for the posit       |
// |            reciprocal table scheduler.                                 |
// | Contents : sched_req_t (operand + requester tag), rr_pick_t and        |
// |            rr_pick(valid, ptr, n).                                     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package posit_sched_pkg;

  localparam int POSIT_W   = 8;   // the shared table is 8-bit ES=1
  localparam int MAX_REQ   = 16;  // largest supported requester count
  localparam int MAX_TAG_W = 4;   // tag width that covers MAX_REQ

  // One in-flight request: posit operand plus the index that issued it.
  typedef struct packed {
    logic [POSIT_W-1:0]   operand;
    logic [MAX_TAG_W-1:0] tag;
  } sched_req_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_TAG_W-1:0] idx;
  } rr_pick_t;

  // First asserted valid bit found scanning upward from ptr, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                       input logic [MAX_TAG_W-1:0] ptr,
                                       input int unsigned          n);
    rr_pick_t    pick;
    int unsigned cand;
    pick = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      cand = (32'(ptr) + i) % n;
      if (!pick.found && (i < n) && valid[cand[MAX_TAG_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = cand[MAX_TAG_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/PositPacked.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface: PositPacked                                                 |
// | Purpose  : Carries one packed posit word between blocks.               |
// | Ports    : bits - posit encoding; src drives it, sink reads it.        |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface PositPacked #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] bits;
  modport src  (output bits);
  modport sink (input  bits);
endinterface
`default_nettype wire

// File: rtl/PositLUT_Inv_8_1.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : PositLUT_Inv_8_1                                            |
// | Purpose  : Combinational reciprocal table for 8-bit ES=1 posits,       |
// |            correctly rounded (nearest, ties to even pattern), never    |
// |            rounding to zero or NaR.  1/0 = NaR, 1/NaR = NaR.           |
// | Ports    : x (sink) - operand posit                                    |
// |            y (src)  - 1/x posit                                        |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module PositLUT_Inv_8_1 (
  PositPacked.sink x,
  PositPacked.src  y
);

  function automatic logic [7:0] posit_recip(input logic [7:0] p);
    logic [6:0]  body;
    int          run;
    logic        done;
    logic        e_in;
    logic [3:0]  frac_in;
    int          sc;
    int          kr;
    logic        e_out;
    logic [15:0] frac_out;
    logic        st;
    logic [47:0] v;
    logic        rnd;
    logic [7:0]  res;

    if (p[6:0] == 7'd0) return 8'h80;

    // Work on the magnitude; the sign is reapplied at the end.
    body = 7'(p[7] ? (~p + 8'd1) : p);
    run  = 1;
    done = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (!done && (body[i] == body[6])) run = run + 1;
      else                               done = 1'b1;
    end
    // Bits after the regime terminator: one exponent bit, up to 4 fraction bits.
    {e_in, frac_in} = 5'((body << (run + 1)) >> 2);
    sc = body[6] ? (2 * (run - 1)) : (-2 * run);
    sc = sc + (e_in ? 1 : 0);

    if (frac_in == 4'd0) begin
      // Power of two: exact reciprocal.
      sc       = -sc;
      frac_out = '0;
      st       = 1'b0;
    end else begin
      // 1/(1+f) = 2^-1 * 32/m with m = 16+F, 32/m in (1,2).
      frac_out = 16'(22'h200000 / {17'd0, 1'b1, frac_in});
      st       = (22'h200000 % {17'd0, 1'b1, frac_in}) != 22'd0;
      sc       = -sc - 1;
    end
    kr    = sc >>> 1;
    e_out = sc[0];

    // Lay out regime | exponent | fraction left-aligned, then round at 7 bits.
    if (kr >= 0) v = 48'($signed({2'b10, e_out, frac_out, 29'd0}) >>> kr);
    else         v = {2'b01, e_out, frac_out, 29'd0} >> (-kr - 1);
    rnd = v[40] & (v[41] | (|v[39:0]) | st);
    res = {1'b0, v[47:41]} + {7'd0, rnd};

    if ((kr > 6) || res[7]) res = 8'h7F;
    else if (kr < -6)       res = 8'h01;
    return p[7] ? (~res + 8'd1) : res;
  endfunction

  assign y.bits = posit_recip(x.bits);

endmodule
`default_nettype wire

// File: rtl/posit_lut_rr_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : posit_lut_rr_sched                                          |
// | Purpose  : Round-robin sharing of one 8-bit ES=1 posit reciprocal      |
// |            table among NUM_REQ requesters; two-stage pipeline with a   |
// |            tagged, back-pressured result stream.                       |
// | Ports    : clock, reset      - clock, async active-high reset          |
// |            req_valid/ready  - per-requester handshake (ready one-hot)  |
// |            req_data         - per-requester posit operand              |
// |            out_valid/ready  - result handshake                         |
// |            out_data/out_tag - 1/x and issuing requester index          |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module posit_lut_rr_sched
  import posit_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [TAG_W-1:0]              out_tag
);

  sched_req_t       r_s1;
  sched_req_t       r_s2;
  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [TAG_W-1:0] r_rr_ptr;

  rr_pick_t         w_pick;
  logic [TAG_W-1:0] w_win;
  logic [TAG_W-1:0] w_ptr_inc;
  logic             w_s1_load;
  logic             w_s2_load;
  logic             w_accept;

  PositPacked #(.WIDTH(POSIT_W)) u_lut_in_if ();
  PositPacked #(.WIDTH(POSIT_W)) u_lut_out_if ();

  assign u_lut_in_if.bits = r_s1.operand;

  PositLUT_Inv_8_1 u_lut (
    .x (u_lut_in_if),
    .y (u_lut_out_if)
  );

  assign w_pick    = rr_pick(MAX_REQ'(req_valid), MAX_TAG_W'(r_rr_ptr), NUM_REQ);
  assign w_win     = TAG_W'(w_pick.idx);
  assign w_ptr_inc = (w_win == TAG_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  // Both stages can move in the cycle the output drains, giving 1/cycle.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  // Reset gates the grant so no requester sees ready while reset is high.
  assign w_accept  = w_pick.found && w_s1_load && !reset;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_win] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else begin
      if (w_accept) r_rr_ptr <= w_ptr_inc;
      if (w_s1_load) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1.operand <= req_data[w_win];
          r_s1.tag     <= MAX_TAG_W'(w_win);
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2.operand <= u_lut_out_if.bits;
          r_s2.tag     <= r_s1.tag;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2.operand;
  assign out_tag   = TAG_W'(r_s2.tag);

endmodule
`default_nettype wire

// File: tb/tb_posit_lut_rr_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_posit_lut_rr_sched                                       |
// | Purpose  : Directed self-checking bench for posit_lut_rr_sched.        |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_posit_lut_rr_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int TAG_W   = 2;

  logic                          clock;
  logic                          reset;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [WIDTH-1:0]              out_data;
  logic [TAG_W-1:0]              out_tag;

  int n_checks = 0;
  int n_errors = 0;

  // Per-requester operands and their hand-computed reciprocals.
  logic [7:0] op_in  [NUM_REQ] = '{8'h40, 8'h50, 8'h48, 8'h7F};
  logic [7:0] op_exp [NUM_REQ] = '{8'h40, 8'h30, 8'h35, 8'h01};

  // Backpressure scenario: expected ready and output tag per cycle (-1 = idle).
  logic [3:0] bp_rdy [9] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                             4'b0100, 4'b0000, 4'b0000, 4'b0000};
  int         bp_tag [9] = '{-1, -1, 0, 0, 0, 0, 1, 2, -1};

  // Skip-idle scenario.
  logic [3:0] sk_vld [7] = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] sk_rdy [7] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
  int         sk_tag [7] = '{-1, -1, 1, 3, 1, 3, -1};

  posit_lut_rr_sched #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < NUM_REQ; i++) req_data[i] = op_in[i];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic expect_out(input string nm, input int tag);
    check_eq({nm, "_vld"}, 32'(out_valid), 32'd1);
    check_eq({nm, "_tag"}, 32'(out_tag), 32'(tag));
    check_eq({nm, "_dat"}, 32'(out_data), 32'(op_exp[tag]));
  endtask

  // One isolated request: ready, latency, result, then drain.
  task automatic single(input int idx, input logic [7:0] d, input logic [7:0] exp,
                        input string nm);
    req_data[idx]  = d;
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    #1;
    check_eq({nm, "_rdy"}, 32'(req_ready), 32'd1 << idx);
    tick();
    req_valid = '0;
    #1;
    check_eq({nm, "_lat"}, 32'(out_valid), 32'd0);
    tick();
    #1;
    check_eq({nm, "_vld"}, 32'(out_valid), 32'd1);
    check_eq({nm, "_dat"}, 32'(out_data), 32'(exp));
    check_eq({nm, "_tag"}, 32'(out_tag), 32'(idx));
    tick();
    #1;
    check_eq({nm, "_drn"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;

    // Reset state, with requests pending to prove ready is held low.
    tick();
    tick();
    req_valid = '1;
    #1;
    check_eq("rst_rdy", 32'(req_ready), 32'd0);
    check_eq("rst_vld", 32'(out_valid), 32'd0);
    check_eq("rst_dat", 32'(out_data), 32'd0);
    check_eq("rst_tag", 32'(out_tag), 32'd0);
    req_valid = '0;
    reset     = 1'b0;
    tick();

    // Single requester, including special values and extremes.
    single(2, 8'h40, 8'h40, "one_40");
    single(2, 8'h50, 8'h30, "one_50");
    single(2, 8'h00, 8'h80, "one_00");
    single(2, 8'h80, 8'h80, "one_80");
    single(2, 8'h48, 8'h35, "one_48");
    single(2, 8'hB8, 8'hCB, "one_b8");
    single(2, 8'h7F, 8'h01, "one_7f");
    single(2, 8'h01, 8'h7F, "one_01");

    // Fairness: all requesters held valid from reset.
    do_reset();
    load_ops();
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      if (c >= 8) req_valid = '0;
      #1;
      if (c < 8) check_eq($sformatf("fair_rdy%0d", c), 32'(req_ready), 32'd1 << (c % 4));
      if (c >= 2) expect_out($sformatf("fair%0d", c), (c - 2) % 4);
      tick();
    end
    #1;
    check_eq("fair_end", 32'(out_valid), 32'd0);

    // Backpressure for 5 cycles, then drain-and-fill on release.
    out_ready = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 9; c++) begin
      if (c == 5) out_ready = 1'b1;
      if (c >= 6) req_valid = '0;
      #1;
      check_eq($sformatf("bp_rdy%0d", c), 32'(req_ready), 32'(bp_rdy[c]));
      if (bp_tag[c] >= 0) expect_out($sformatf("bp%0d", c), bp_tag[c]);
      else if (c == 8)    check_eq("bp_end", 32'(out_valid), 32'd0);
      tick();
    end

    // Skip idle: a grant to 1 leaves the pointer at 2, then 3,1,3.
    for (int c = 0; c < 7; c++) begin
      req_valid = sk_vld[c];
      #1;
      check_eq($sformatf("sk_rdy%0d", c), 32'(req_ready), 32'(sk_rdy[c]));
      if (sk_tag[c] >= 0) expect_out($sformatf("sk%0d", c), sk_tag[c]);
      else if (c == 6)    check_eq("sk_end", 32'(out_valid), 32'd0);
      tick();
    end

    // Reset mid-operation with both stages full.
    out_ready = 1'b0;
    req_valid = '1;
    #1;
    tick();
    tick();
    #1;
    check_eq("mid_full", 32'(out_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_eq("mid_vld", 32'(out_valid), 32'd0);
    check_eq("mid_dat", 32'(out_data), 32'd0);
    check_eq("mid_tag", 32'(out_tag), 32'd0);
    check_eq("mid_rdy", 32'(req_ready), 32'd0);
    tick();
    out_ready = 1'b1;
    reset     = 1'b0;
    #1;
    check_eq("post_rdy", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    #1;
    check_eq("post_stale", 32'(out_valid), 32'd0);
    tick();
    #1;
    expect_out("post", 0);
    tick();
    #1;
    check_eq("post_end", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
